memory_stage: RTL and testbench

Pipeline stage directly downstream of `execute_stage`. It registers the execute outputs (control word, data word, ALU result, store data) and turns loads and stores into a valid/ready data-memory transaction. It stalls the pipeline until the transaction completes, then aligns and sign- or zero-extends load data. It passes control and data words to writeback and supplies the memory-stage forwarding value back to execute.

---
 rtl/rvga_types.sv | 43 ++++
 rtl/dff.sv | 26 ++
 rtl/rvga_lsu_align.sv | 57 +++++
 rtl/memory_stage.sv | 143 ++++++++++++++
 tb/tb_memory_stage.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvga_types.sv
`default_nettype none
// ============================================================================
// Module : rvga_types
// Desc   : Shared pipeline word types, load/store funct3 encodings and the
//          memory-stage state type.
// Rev    : 1.0  initial release
// ============================================================================
package rvga_types;

    typedef logic [31:0] rvga_word;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef struct packed {
        logic [4:0] rd_addr;
        logic       rf_w_v;
        logic       dmem_r_v;
        logic       dmem_w_v;
        logic [2:0] funct3;
    } rvga_cword;

    typedef struct packed {
        rvga_word pc;
        rvga_word alu_result;
        rvga_word ld_result;
    } rvga_dword;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } rvga_mem_state_e;

    function automatic logic is_mem_op(input rvga_cword cw);
        return cw.dmem_r_v | cw.dmem_w_v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
// Module : dff
// Desc   : Write-enabled register with asynchronous active-high clear.
// Rev    : 1.0  initial release
// ============================================================================
module dff #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             w_v_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (w_v_i) begin
            q_o <= d_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rvga_lsu_align.sv
`default_nettype none
// ============================================================================
// Module : rvga_lsu_align
// Desc   : Byte-lane steering for stores and alignment/extension for loads.
// Rev    : 1.0  initial release
// ============================================================================
module rvga_lsu_align
    import rvga_types::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] w_shifted;

    assign w_shifted = rdata_i >> {offset_i, 3'b000};

    // Size is carried in funct3[1:0] for both loads and stores.
    always_comb begin
        wmask_o      = 4'b1111;
        wdata_o      = st_data_i;
        misaligned_o = |offset_i;
        case (funct3_i[1:0])
            2'b00: begin
                wmask_o      = 4'b0001 << offset_i;
                wdata_o      = {4{st_data_i[7:0]}};
                misaligned_o = 1'b0;
            end
            2'b01: begin
                wmask_o      = 4'b0011 << offset_i;
                wdata_o      = {2{st_data_i[15:0]}};
                misaligned_o = offset_i[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data_o = w_shifted;
        case (funct3_i)
            c_F3_B:  ld_data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_F3_H:  ld_data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_F3_BU: ld_data_o = {24'b0, w_shifted[7:0]};
            c_F3_HU: ld_data_o = {16'b0, w_shifted[15:0]};
            c_F3_W:  ld_data_o = w_shifted;
            default: ld_data_o = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module : memory_stage
// Desc   : Memory pipeline stage; issues valid/ready data-memory requests and
//          stalls the pipeline until each load/store completes.
// Rev    : 1.0  initial release
// ============================================================================
module memory_stage
    import rvga_types::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_v_i,
    input  rvga_cword   cword_i,
    input  rvga_dword   dword_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] st_data_i,
    output rvga_cword   cword_o,
    output rvga_dword   dword_o,
    output logic [31:0] rd_data_o,
    output logic        dmem_r_v_o,
    output logic        dmem_w_v_o,
    input  logic        dmem_ready_i,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wmask_o,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_v_o,
    output logic        misaligned_v_o
);

    rvga_cword       r_cword;
    rvga_dword       r_dword;
    logic [31:0]     r_alu;
    logic [31:0]     r_st_data;
    logic [31:0]     r_ld_data;
    rvga_mem_state_e r_state;
    rvga_mem_state_e w_state_next;

    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_issue;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_ext;
    logic        w_unused_dword;

    dff #(.WIDTH($bits(rvga_cword))) u_cword_reg (
        .clk_i(clk_i), .rst_i(rst_i), .w_v_i(~stall_v_i), .d_i(cword_i), .q_o(r_cword)
    );
    dff #(.WIDTH($bits(rvga_dword))) u_dword_reg (
        .clk_i(clk_i), .rst_i(rst_i), .w_v_i(~stall_v_i), .d_i(dword_i), .q_o(r_dword)
    );
    dff #(.WIDTH(32)) u_alu_reg (
        .clk_i(clk_i), .rst_i(rst_i), .w_v_i(~stall_v_i), .d_i(alu_result_i), .q_o(r_alu)
    );
    dff #(.WIDTH(32)) u_st_data_reg (
        .clk_i(clk_i), .rst_i(rst_i), .w_v_i(~stall_v_i), .d_i(st_data_i), .q_o(r_st_data)
    );

    rvga_lsu_align u_align (
        .funct3_i    (r_cword.funct3),
        .offset_i    (r_alu[1:0]),
        .st_data_i   (r_st_data),
        .rdata_i     (dmem_rdata_i),
        .wmask_o     (w_mask),
        .wdata_o     (w_wdata),
        .misaligned_o(w_misaligned),
        .ld_data_o   (w_ld_ext)
    );

    assign w_mem_op = is_mem_op(r_cword);
    assign w_issue  = w_mem_op & ~w_misaligned;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DONE waits for the pipeline to advance so a held instruction is never re-issued.
    always_comb begin
        w_state_next = r_state;
        dmem_r_v_o   = 1'b0;
        dmem_w_v_o   = 1'b0;
        stall_v_o    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    dmem_r_v_o = r_cword.dmem_r_v;
                    dmem_w_v_o = r_cword.dmem_w_v & ~r_cword.dmem_r_v;
                    stall_v_o  = 1'b1;
                    if (dmem_ready_i) begin
                        w_state_next = r_cword.dmem_r_v ? WAIT : DONE;
                    end
                end
            end
            WAIT: begin
                stall_v_o = 1'b1;
                if (dmem_rvalid_i) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (~stall_v_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ld_data <= '0;
        end else if ((r_state == WAIT) && dmem_rvalid_i) begin
            r_ld_data <= w_ld_ext;
        end else if (~stall_v_i) begin
            r_ld_data <= '0;
        end
    end

    assign dmem_addr_o    = {r_alu[31:2], 2'b00};
    assign dmem_wdata_o   = w_wdata;
    assign dmem_wmask_o   = w_mem_op ? w_mask : 4'b0000;
    assign misaligned_v_o = w_mem_op & w_misaligned;
    assign rd_data_o      = r_alu;
    assign cword_o        = r_cword;

    always_comb begin
        dword_o            = r_dword;
        dword_o.alu_result = r_alu;
        dword_o.ld_result  = r_ld_data;
    end

    // The execute-side result fields are superseded by this stage's own registers.
    assign w_unused_dword = ^{r_dword.alu_result, r_dword.ld_result};

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_memory_stage
// Desc   : Scoreboard bench for memory_stage with a byte-level memory model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_memory_stage;
    import rvga_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ext_stall = 1'b0;
    logic        stall_v_i;
    rvga_cword   cword_i = '0;
    rvga_dword   dword_i = '0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] st_data_i = '0;
    rvga_cword   cword_o;
    rvga_dword   dword_o;
    logic [31:0] rd_data_o;
    logic        dmem_r_v_o, dmem_w_v_o;
    logic        dmem_ready_i = 1'b0;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_wmask_o;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        stall_v_o, misaligned_v_o;

    assign stall_v_i = ext_stall | stall_v_o;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk_i(clk), .rst_i(rst), .stall_v_i(stall_v_i),
        .cword_i(cword_i), .dword_i(dword_i), .alu_result_i(alu_result_i), .st_data_i(st_data_i),
        .cword_o(cword_o), .dword_o(dword_o), .rd_data_o(rd_data_o),
        .dmem_r_v_o(dmem_r_v_o), .dmem_w_v_o(dmem_w_v_o), .dmem_ready_i(dmem_ready_i),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_v_o(stall_v_o), .misaligned_v_o(misaligned_v_o)
    );

    typedef struct {
        rvga_cword   cw;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        mis;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [31:0] dev_mem [0:1023];
    logic [7:0]  ref_mem [0:4095];

    int errors = 0;
    int checks = 0;
    int stall_cnt = 0;
    int acc_cnt = 0;
    int stall_pct = 0;
    int ready_pct = 100;
    int fixed_delay = 0;
    int hold_low = 0;
    logic [31:0] pc_tag = 32'd0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
        logic [31:0] v = '0;
        for (int i = 0; i < acc_size(f3); i++) v[8*i +: 8] = ref_mem[a + i];
        if (f3 == c_F3_B && v[7])  v[31:8]  = '1;
        if (f3 == c_F3_H && v[15]) v[31:16] = '1;
        return v;
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store. Call at a falling edge.
    task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        req_t r;
        int   n, ia, guard;
        logic loaded;
        pc_tag += 32'd4;
        n  = acc_size(f3);
        ia = int'(a[11:0]);
        cword_i          = '0;
        cword_i.rd_addr  = 5'($urandom);
        cword_i.rf_w_v   = 1'($urandom);
        cword_i.funct3   = f3;
        cword_i.dmem_r_v = (kind == 1);
        cword_i.dmem_w_v = (kind == 2);
        dword_i.pc         = pc_tag;
        dword_i.alu_result = $urandom;
        dword_i.ld_result  = $urandom;
        alu_result_i = a;
        st_data_i    = d;
        e.cw  = cword_i;
        e.pc  = pc_tag;
        e.alu = a;
        e.mis = (kind != 0) && ((ia % n) != 0);
        e.ld  = '0;
        if (kind != 0 && !e.mis) begin
            r.we    = (kind == 2);
            r.addr  = {a[31:2], 2'b00};
            r.mask  = '0;
            for (int i = 0; i < n; i++) r.mask[(ia % 4) + i] = 1'b1;
            r.wdata = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
            req_q.push_back(r);
            if (kind == 1) e.ld = ref_load(ia, f3);
            else for (int i = 0; i < n; i++) ref_mem[ia + i] = d[8*i +: 8];
        end
        exp_q.push_back(e);
        loaded = 1'b0;
        guard  = 0;
        while (!loaded) begin
            ext_stall = (stall_pct != 0) && ($urandom_range(99) < stall_pct);
            #1;
            loaded = !stall_v_i;
            @(negedge clk);
            guard++;
            if (!loaded && guard > 200) begin
                checks++;
                errors++;
                $display("FAIL load_timeout: pc=%0h not accepted by stage after %0d cycles", pc_tag, guard);
                break;
            end
        end
        cword_i = '0; dword_i = '0; alu_result_i = '0; st_data_i = '0; ext_stall = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        ext_stall = 1'b0;
        while ((exp_q.size() != 0 || req_q.size() != 0) && g < 300) begin
            @(negedge clk); #3; g++;
        end
        checks++;
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            errors++;
            $display("FAIL drain: outstanding results=%0d requests=%0d required 0", exp_q.size(), req_q.size());
            exp_q.delete();
            req_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cword"}, 96'(cword_o), 96'd0);
        chk({tag, "_dword"}, dword_o, 96'd0);
        chk({tag, "_rd_data"}, 96'(rd_data_o), 96'd0);
        chk({tag, "_ctrl"}, 96'({dmem_r_v_o, dmem_w_v_o, stall_v_o, misaligned_v_o}), 96'd0);
    endtask

    // Retirement monitor: an instruction leaves the stage at any edge where it advances.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && !stall_v_i && dword_o.pc != 32'd0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL retire: unexpected pc=%0h required none", dword_o.pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc", 96'(dword_o.pc), 96'(e.pc));
                    chk("cword", 96'(cword_o), 96'(e.cw));
                    chk("alu_result", 96'(dword_o.alu_result), 96'(e.alu));
                    chk("rd_data", 96'(rd_data_o), 96'(e.alu));
                    chk("ld_result", 96'(dword_o.ld_result), 96'(e.ld));
                    chk("misaligned", 96'(misaligned_v_o), 96'(e.mis));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk); #2;
            if (stall_v_o) stall_cnt++;
        end
    end

    // Memory device: checks each presented request against the expected queue.
    initial begin
        logic        pend = 1'b0;
        int          cnt = 0;
        logic [31:0] paddr = '0;
        req_t        r;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                dmem_rvalid_i = 1'b0;
                dmem_ready_i  = 1'b0;
            end else begin
                dmem_rvalid_i = 1'b0;
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        dmem_rvalid_i = 1'b1;
                        dmem_rdata_i  = dev_mem[paddr[11:2]];
                        pend = 1'b0;
                    end
                end
                if ((dmem_r_v_o || dmem_w_v_o) && hold_low > 0) begin
                    dmem_ready_i = 1'b0;
                    hold_low--;
                end else begin
                    dmem_ready_i = (ready_pct >= 100) || ($urandom_range(99) < ready_pct);
                end
                #3;
                if (dmem_r_v_o || dmem_w_v_o) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL request: unexpected request addr=%0h required none", dmem_addr_o);
                    end else begin
                        r = req_q[0];
                        chk("req_kind", 96'({dmem_r_v_o, dmem_w_v_o}), 96'({!r.we, r.we}));
                        chk("req_addr", 96'(dmem_addr_o), 96'(r.addr));
                        if (r.we) begin
                            chk("req_mask", 96'(dmem_wmask_o), 96'(r.mask));
                            chk("req_wdata", 96'(dmem_wdata_o), 96'(r.wdata));
                        end
                        if (dmem_ready_i) begin
                            void'(req_q.pop_front());
                            acc_cnt++;
                            if (dmem_w_v_o) begin
                                for (int b = 0; b < 4; b++)
                                    if (dmem_wmask_o[b]) dev_mem[dmem_addr_o[11:2]][8*b +: 8] = dmem_wdata_o[8*b +: 8];
                            end else begin
                                pend  = 1'b1;
                                paddr = dmem_addr_o;
                                cnt   = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(4, 1));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int          kind, n, acc0, guard;
        logic [2:0]  f3;
        logic [31:0] a, w;
        logic [2:0]  ld_f3 [5];
        ld_f3 = '{c_F3_B, c_F3_H, c_F3_W, c_F3_BU, c_F3_HU};

        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            dev_mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        dev_mem[32'h200 >> 2] = 32'h8001_0000;
        for (int b = 0; b < 4; b++) ref_mem[32'h200 + b] = dev_mem[32'h200 >> 2][8*b +: 8];

        @(negedge clk); @(negedge clk); #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        stall_cnt = 0;
        issue(0, 3'b000, 32'h0000_1234, 32'h0);
        drain();
        chk("add_stall_cycles", 96'(stall_cnt), 96'd0);

        stall_cnt = 0;
        issue(2, c_F3_B, 32'h103, 32'hAB);
        drain();
        chk("sb_stall_cycles", 96'(stall_cnt), 96'd1);

        fixed_delay = 3;
        stall_cnt = 0;
        issue(1, c_F3_H, 32'h202, 32'h0);
        drain();
        chk("lh_stall_cycles", 96'(stall_cnt), 96'd4);
        stall_cnt = 0;
        issue(1, c_F3_HU, 32'h202, 32'h0);
        drain();
        chk("lhu_stall_cycles", 96'(stall_cnt), 96'd4);

        fixed_delay = 1;
        hold_low = 5;
        acc0 = acc_cnt;
        stall_cnt = 0;
        issue(1, c_F3_W, 32'h300, 32'h0);
        drain();
        chk("lw_hold_acceptances", 96'(acc_cnt - acc0), 96'd1);
        chk("lw_hold_stall_cycles", 96'(stall_cnt), 96'd7);

        stall_cnt = 0;
        acc0 = acc_cnt;
        issue(1, c_F3_W, 32'h102, 32'h0);
        drain();
        chk("misaligned_stall_cycles", 96'(stall_cnt), 96'd0);
        chk("misaligned_acceptances", 96'(acc_cnt - acc0), 96'd0);

        fixed_delay = 20;
        issue(1, c_F3_W, 32'h400, 32'h0);
        guard = 0;
        while (guard < 30) begin
            @(negedge clk); #2;
            guard++;
            if (stall_v_o && !dmem_r_v_o) break;
        end
        chk("reached_wait", 96'({stall_v_o, dmem_r_v_o}), 96'(2'b10));
        rst = 1'b1;
        #1;
        check_all_zero("reset_in_wait");
        exp_q.delete();
        req_q.delete();
        fixed_delay = 0;
        @(negedge clk); @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        issue(1, c_F3_W, 32'h404, 32'h0);
        drain();

        stall_pct = 25;
        ready_pct = 60;
        for (int k = 0; k < 150; k++) begin
            kind = int'($urandom_range(2));
            f3   = (kind == 1) ? ld_f3[$urandom_range(4)] :
                   (kind == 2) ? 3'($urandom_range(2)) : 3'($urandom);
            n    = acc_size(f3);
            if (kind == 0) begin
                a = $urandom;
            end else begin
                a = 32'($urandom_range(4095));
                if ($urandom_range(3) != 0) begin
                    if (n == 2) a[0] = 1'b0;
                    if (n == 4) a[1:0] = 2'b00;
                end
            end
            issue(kind, f3, a, $urandom);
            if ($urandom_range(4) == 0) @(negedge clk);
        end
        stall_pct = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
